cpu64_l1_traffic_gen: RTL and testbench



---
 rtl/cpu64_l1_tg_pkg.sv | 20 ++
 rtl/cpu64_l1_tg_shadow.sv | 48 ++++
 rtl/cpu64_l1_traffic_gen.sv | 199 +++++++++++++++++++
 tb/tb_cpu64_l1_traffic_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu64_l1_tg_pkg.sv
// rtl/cpu64_l1_tg_pkg.sv - shared types, constants and LFSR step for the L1 traffic generator
package cpu64_l1_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_REQ,
    ST_WAIT_RV,
    ST_DONE
  } tg_state_e;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] LANE_XOR  = 32'hA5A5_A5A5;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/cpu64_l1_tg_shadow.sv
// rtl/cpu64_l1_tg_shadow.sv - byte-masked shadow memory with per-byte valid masks
module cpu64_l1_tg_shadow
  import cpu64_l1_tg_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned WIN_WORDS = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic                         we_i,
  input  logic [$clog2(WIN_WORDS)-1:0] widx_i,
  input  logic [DATA_W/8-1:0]          wbe_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [$clog2(WIN_WORDS)-1:0] ridx_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic [DATA_W/8-1:0]          rvalid_o
);

  localparam int unsigned BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [WIN_WORDS];
  logic [BE_W-1:0]   vld_q [WIN_WORDS];

  // Data bytes need no reset: the valid mask hides anything never written.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wbe_i[b]) mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Valid masks accumulate written bytes and are wiped at the start of every run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < WIN_WORDS; w++) vld_q[w] <= '0;
    end else if (clr_i) begin
      for (int w = 0; w < WIN_WORDS; w++) vld_q[w] <= '0;
    end else if (we_i) begin
      vld_q[widx_i] <= vld_q[widx_i] | wbe_i;
    end
  end

  assign rdata_o  = mem_q[ridx_i];
  assign rvalid_o = vld_q[ridx_i];

endmodule

// File: rtl/cpu64_l1_traffic_gen.sv
// rtl/cpu64_l1_traffic_gen.sv - LFSR-driven L1 CPU-port traffic generator and read checker
module cpu64_l1_traffic_gen
  import cpu64_l1_tg_pkg::*;
#(
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h1000,
  parameter int unsigned       WIN_WORDS = 16,
  parameter int unsigned       NUM_OPS   = 64,
  parameter logic [31:0]       SEED      = 32'hACE1_2345,
  parameter int unsigned       TIMEOUT   = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  output logic                req_o,
  output logic                we_o,
  output logic [DATA_W/8-1:0] be_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   wdata_o,
  input  logic                gnt_i,
  input  logic                rvalid_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic                timeout_o,
  output logic [15:0]         err_cnt_o,
  output logic [15:0]         op_cnt_o,
  output logic [ADDR_W-1:0]   first_err_addr_o
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned IDX_W    = $clog2(WIN_WORDS);
  localparam int unsigned OFF_W    = $clog2(BE_W);
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  tg_state_e         state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d, lfsr_nxt;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d, gen_be, sh_valid;
  logic [ADDR_W-1:0] addr_q, addr_d, first_err_q, first_err_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, gen_wdata, sh_rdata, cmp_mask;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       op_cnt_q, op_cnt_d, err_cnt_q, err_cnt_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       wd_q, wd_d;
  logic              clr, sh_we, mismatch, last_op, wd_expired;

  cpu64_l1_tg_shadow #(
    .DATA_W    (DATA_W),
    .WIN_WORDS (WIN_WORDS)
  ) u_shadow (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (clr),
    .we_i     (sh_we),
    .widx_i   (idx_q),
    .wbe_i    (be_q),
    .wdata_i  (wdata_q),
    .ridx_i   (idx_q),
    .rdata_o  (sh_rdata),
    .rvalid_o (sh_valid)
  );

  // Field decode of the next LFSR value and the byte-masked read compare.
  always_comb begin
    lfsr_nxt  = lfsr_step(lfsr_q);
    gen_be    = lfsr_nxt[31 -: BE_W];
    if (gen_be == '0) gen_be = '1;
    gen_wdata = DATA_W'(lfsr_nxt);
    for (int i = 0; i < int'(DATA_W / 32); i++) begin
      gen_wdata[32*i +: 32] = ((i % 2) == 1) ? (lfsr_nxt ^ LANE_XOR) : lfsr_nxt;
    end
    for (int b = 0; b < BE_W; b++) cmp_mask[8*b +: 8] = {8{sh_valid[b]}};
    mismatch   = |((rdata_i ^ sh_rdata) & cmp_mask);
    last_op    = (op_cnt_q + 16'd1) == 16'(NUM_OPS);
    wd_expired = wd_q == 32'(TIMEOUT - 1);
  end

  // Sequencer: next state, payload capture, counters and watchdog.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    op_cnt_d    = op_cnt_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    timeout_d   = timeout_q;
    wd_d        = wd_q;
    clr         = 1'b0;
    sh_we       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          clr         = 1'b1;
          lfsr_d      = SEED_EFF;
          op_cnt_d    = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
          timeout_d   = 1'b0;
          state_d     = ST_GEN;
        end
      end
      ST_GEN: begin
        lfsr_d  = lfsr_nxt;
        we_d    = lfsr_nxt[0];
        be_d    = lfsr_nxt[0] ? gen_be : '0;
        idx_d   = lfsr_nxt[IDX_W:1];
        addr_d  = BASE_ADDR + (ADDR_W'(lfsr_nxt[IDX_W:1]) << OFF_W);
        wdata_d = gen_wdata;
        wd_d    = '0;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (gnt_i) begin
          if (we_q) begin
            sh_we    = 1'b1;
            op_cnt_d = op_cnt_q + 16'd1;
            state_d  = last_op ? ST_DONE : ST_GEN;
          end else begin
            wd_d    = '0;
            state_d = ST_WAIT_RV;
          end
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      ST_WAIT_RV: begin
        if (rvalid_i) begin
          if (mismatch) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (err_cnt_q == 16'd0) first_err_d = addr_q;
          end
          op_cnt_d = op_cnt_q + 16'd1;
          state_d  = last_op ? ST_DONE : ST_GEN;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      op_cnt_q    <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      timeout_q   <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      op_cnt_q    <= op_cnt_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      timeout_q   <= timeout_d;
      wd_q        <= wd_d;
    end
  end

  assign req_o            = (state_q == ST_REQ);
  assign we_o             = we_q;
  assign be_o             = be_q;
  assign addr_o           = addr_q;
  assign wdata_o          = wdata_q;
  assign busy_o           = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o           = (state_q == ST_DONE);
  assign pass_o           = (state_q == ST_DONE) && (err_cnt_q == 16'd0) && !timeout_q;
  assign timeout_o        = timeout_q;
  assign err_cnt_o        = err_cnt_q;
  assign op_cnt_o         = op_cnt_q;
  assign first_err_addr_o = first_err_q;

endmodule

// File: tb/tb_cpu64_l1_traffic_gen.sv
// tb/tb_cpu64_l1_traffic_gen.sv - randomized bench for cpu64_l1_traffic_gen with an op-level reference model
module tb_cpu64_l1_traffic_gen;

  localparam int          NOPS = 64;
  localparam int          WIN  = 16;
  localparam logic [63:0] BASE = 64'h1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_ni, start_i, start2, gnt_i, rvalid_i;
  logic [63:0] rdata_i;
  logic        req_o, we_o, busy_o, done_o, pass_o, timeout_o;
  logic [7:0]  be_o;
  logic [63:0] addr_o, wdata_o, first_err_addr_o;
  logic [15:0] err_cnt_o, op_cnt_o;
  logic        req2, we2, busy2, done2, pass2, to2;
  logic [7:0]  be2;
  logic [63:0] addr2, wdata2, first2;
  logic [15:0] err2, op2;

  cpu64_l1_traffic_gen dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
    .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .err_cnt_o(err_cnt_o), .op_cnt_o(op_cnt_o), .first_err_addr_o(first_err_addr_o)
  );

  cpu64_l1_traffic_gen #(.TIMEOUT(16)) dut_to (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start2),
    .req_o(req2), .we_o(we2), .be_o(be2), .addr_o(addr2), .wdata_o(wdata2),
    .gnt_i(1'b0), .rvalid_i(1'b0), .rdata_i(64'd0),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .timeout_o(to2),
    .err_cnt_o(err2), .op_cnt_o(op2), .first_err_addr_o(first2)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: expected op list from the LFSR rules, plus a memory and valid-byte model.
  logic        exp_we   [NOPS];
  int          exp_idx  [NOPS];
  logic [63:0] exp_addr [NOPS];
  logic [7:0]  exp_be   [NOPS];
  logic [63:0] exp_wd   [NOPS];
  logic [63:0] mem      [WIN];
  logic [7:0]  vmask    [WIN];
  int          k, exp_err, fault, rd_dly;
  logic [63:0] exp_first, rd_resp;
  bit          rd_pend;

  task automatic accept();
    int          idx;
    logic [63:0] r, bm;
    if (k >= NOPS) begin
      check("op_overrun", 128'(k), 128'(NOPS - 1));
      return;
    end
    check("req_payload", 128'({we_o, be_o, addr_o}), 128'({exp_we[k], exp_be[k], exp_addr[k]}));
    idx = exp_idx[k];
    if (exp_we[k]) begin
      check("wdata", 128'(wdata_o), 128'(exp_wd[k]));
      for (int b = 0; b < 8; b++) if (be_o[b]) mem[idx][8*b +: 8] = wdata_o[8*b +: 8];
      vmask[idx] = vmask[idx] | be_o;
    end else begin
      r = mem[idx];
      if (fault == 1) r[32] = 1'b1;
      else if (fault == 2 && $urandom_range(0, 2) == 0) r = r ^ (64'd1 << $urandom_range(0, 63));
      for (int b = 0; b < 8; b++) bm[8*b +: 8] = {8{vmask[idx][b]}};
      if (((r ^ mem[idx]) & bm) != 64'd0) begin
        if (exp_err == 0) exp_first = exp_addr[k];
        exp_err++;
      end
      rd_resp = r;
      rd_dly  = $urandom_range(0, 3);
      rd_pend = 1'b1;
    end
    k++;
  endtask

  // Memory-side responder: random grant, random read latency, stray rvalid while in REQ.
  initial begin
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
    forever begin
      @(negedge clk);
      gnt_i    = 1'b0;
      rvalid_i = 1'b0;
      rdata_i  = {$urandom, $urandom};
      if (rd_pend) begin
        if (rd_dly == 0) begin
          rvalid_i = 1'b1;
          rdata_i  = rd_resp;
          rd_pend  = 1'b0;
        end else begin
          rd_dly--;
        end
      end else if (req_o && rst_ni) begin
        if ($urandom_range(0, 3) != 0) begin
          gnt_i = 1'b1;
          accept();
        end else if ($urandom_range(0, 1) == 0) begin
          rvalid_i = 1'b1;
        end
      end
    end
  end

  task automatic model_reset(input int mode);
    for (int i = 0; i < WIN; i++) vmask[i] = 8'h00;
    k = 0; exp_err = 0; exp_first = '0; fault = mode; rd_pend = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 128'({req_o, we_o, be_o, busy_o, done_o, pass_o, timeout_o, err_cnt_o, op_cnt_o}), 128'd0);
    check({tag, "_addr"}, 128'(addr_o), 128'd0);
    check({tag, "_wdata"}, 128'(wdata_o), 128'd0);
    check({tag, "_first"}, 128'(first_err_addr_o), 128'd0);
  endtask

  task automatic run(input int mode, input bit poke);
    int lat, cyc;
    bit poked;
    model_reset(mode);
    poked = 1'b0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    lat = 1;
    while (!req_o && lat < 8) begin @(posedge clk); #1; lat++; end
    check("start_to_req", 128'(lat), 128'd2);
    cyc = 0;
    while (!done_o && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start_i = poke && !poked && (op_cnt_o == 16'd10);
      if (start_i) poked = 1'b1;
    end
    start_i = 1'b0;
    check("done", 128'(done_o), 128'd1);
    check("busy_end", 128'(busy_o), 128'd0);
    check("op_cnt", 128'(op_cnt_o), 128'(NOPS));
    check("model_ops", 128'(k), 128'(NOPS));
    check("err_cnt", 128'(err_cnt_o), 128'(exp_err));
    check("first_err", 128'(first_err_addr_o), 128'(exp_first));
    check("pass", 128'(pass_o), 128'(exp_err == 0));
    check("timeout", 128'(timeout_o), 128'd0);
    if (mode == 1) begin
      check("stuck_seen", 128'(err_cnt_o != 16'd0), 128'd1);
      check("first_in_win", 128'(first_err_addr_o >= BASE && first_err_addr_o <= BASE + 64'h78), 128'd1);
    end
  endtask

  initial begin
    logic [31:0] s;
    int          cyc;
    s = 32'hACE1_2345;
    for (int i = 0; i < NOPS; i++) begin
      s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
      exp_we[i]   = s[0];
      exp_idx[i]  = int'((s >> 1) % WIN);
      exp_addr[i] = BASE + 64'(exp_idx[i] * 8);
      exp_be[i]   = !s[0] ? 8'h00 : (s[31:24] == 8'h00) ? 8'hFF : s[31:24];
      exp_wd[i]   = {s ^ 32'hA5A5_A5A5, s};
    end
    for (int i = 0; i < WIN; i++) mem[i] = {$urandom, $urandom};
    model_reset(0);
    rst_ni = 1'b0; start_i = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_to_ctl", 128'({req2, busy2, done2, pass2, to2}), 128'd0);
    @(negedge clk); rst_ni = 1'b1;

    run(0, 1'b0);
    run(2, 1'b1);
    run(1, 1'b0);

    // Reset in the middle of a read, then the identical sequence again.
    model_reset(0);
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    cyc = 0;
    do begin @(posedge clk); cyc++; end while (!rd_pend && cyc < 500);
    #2 rst_ni = 1'b0;
    #1 check_all_zero("midrd_reset");
    rd_pend = 1'b0;
    @(negedge clk); rst_ni = 1'b1;
    run(0, 1'b0);

    // Watchdog with grant never given.
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    cyc = 1;
    while (!req2 && cyc < 8) begin @(posedge clk); #1; cyc++; end
    check("to_start_req", 128'(cyc), 128'd2);
    cyc = 0;
    while (!to2 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("to_cycles", 128'(cyc), 128'd16);
    check("to_req_low", 128'(req2), 128'd0);
    check("to_done", 128'(done2), 128'd1);
    check("to_pass", 128'(pass2), 128'd0);
    check("to_busy", 128'(busy2), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
